// File: rtl/pipeline_pkg.sv
// Shared types for the fetch stage: FSM encoding, fetch packet, default NOP.
// The optional counters are enabled by PIPE_IF_PERF_EN (see pipeline_if_stage5).
package pipeline_pkg;

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_DROP = 2'd2
   } if_state_t;

   localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] instr;
   } fetch_pkt_t;

   function automatic logic [63:0] align_word(input logic [63:0] addr);
      return {addr[63:2], 2'b00};
   endfunction

endpackage

// File: rtl/if_hold_buf.sv
// One-entry skid buffer holding a fetched {pc,instr} while decode is stalled.
// Flush wins over push; push with pop replaces the entry.
module if_hold_buf
   import pipeline_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       push,
   input  logic       pop,
   input  logic       flush,
   input  fetch_pkt_t din,
   output fetch_pkt_t dout,
   output logic       full
);

   fetch_pkt_t data;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset)      full <= 1'b0;
      else if (flush) full <= 1'b0;
      else if (push)  full <= 1'b1;
      else if (pop)   full <= 1'b0;
   end

   // NOTE: the payload is deliberately not reset; it is only observed while full=1.
   always_ff @(posedge clk) begin
      if (push && !flush) data <= din;
   end

   assign dout = data;

endmodule

// File: rtl/pipeline_if_stage5.sv
// Instruction-fetch stage: single-outstanding imem handshake, hold buffer, EXB redirect.
// Define PIPE_IF_PERF_EN to build the fetch/drop performance counters.
module pipeline_if_stage5
   import pipeline_pkg::*;
#(
   parameter logic [63:0] RESET_PC  = 64'h0000_0000_0000_0000,
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        branch_taken_EXB,
   input  logic [63:0] branch_target_EXB,
   output logic        imem_req,
   output logic [63:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [63:0] pc_IF,
   output logic [31:0] instr_IF,
   output logic        valid_IF,
   output logic [63:0] perf_fetch_cnt,
   output logic [31:0] perf_drop_cnt
);

   if_state_t  state, state_nxt;
   logic [63:0] fetch_pc;

   logic       hold_full;
   fetch_pkt_t hold_dout;
   fetch_pkt_t resp_pkt;
   fetch_pkt_t load_pkt;

   logic resp_live, out_free, load_hold, load_resp, push_hold, out_load;

   // fetch_pc stays on the outstanding request until its response arrives
   assign resp_pkt  = '{pc: fetch_pc, instr: imem_rdata};
   assign resp_live = imem_rvalid && (state == S_WAIT) && !branch_taken_EXB;
   assign out_free  = !stall || !valid_IF;
   assign load_hold = !branch_taken_EXB && out_free && hold_full;
   assign load_resp = !branch_taken_EXB && out_free && !hold_full && resp_live;
   assign push_hold = resp_live && !load_resp;
   assign out_load  = load_hold || load_resp;
   assign load_pkt  = hold_full ? hold_dout : resp_pkt;
   assign imem_addr = fetch_pc;

   if_hold_buf u_hold (
      .clk   (clk),
      .reset (reset),
      .push  (push_hold),
      .pop   (load_hold),
      .flush (branch_taken_EXB),
      .din   (resp_pkt),
      .dout  (hold_dout),
      .full  (hold_full)
   );

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_nxt = state;
      imem_req  = 1'b0;
      case (state)
         S_REQ: begin
            imem_req = !hold_full && !branch_taken_EXB;
            if (imem_req && imem_gnt) state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (imem_rvalid)           state_nxt = S_REQ;
            else if (branch_taken_EXB) state_nxt = S_DROP;
         end
         // a response consumed here closes the stale request even if a new redirect arrives
         S_DROP: begin
            if (imem_rvalid) state_nxt = S_REQ;
         end
         default: state_nxt = S_REQ;
      endcase
      if (reset) imem_req = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_REQ;
         fetch_pc <= align_word(RESET_PC);
      end else begin
         state <= state_nxt;
         if (branch_taken_EXB) fetch_pc <= align_word(branch_target_EXB);
         else if (resp_live)   fetch_pc <= fetch_pc + 64'd4;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_IF <= 1'b0;
         pc_IF    <= '0;
         instr_IF <= NOP_INSTR;
      end else if (branch_taken_EXB) begin
         valid_IF <= 1'b0;
         instr_IF <= NOP_INSTR;
      end else if (out_load) begin
         valid_IF <= 1'b1;
         pc_IF    <= load_pkt.pc;
         instr_IF <= load_pkt.instr;
      end else if (out_free) begin
         valid_IF <= 1'b0;
         instr_IF <= NOP_INSTR;
      end
   end

`ifdef PIPE_IF_PERF_EN
   logic        resp_drop;
   logic [63:0] fetch_cnt;
   logic [31:0] drop_cnt;

   assign resp_drop = imem_rvalid &&
                      ((state == S_DROP) || ((state == S_WAIT) && branch_taken_EXB));

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_cnt <= '0;
         drop_cnt  <= '0;
      end else begin
         if (out_load)  fetch_cnt <= fetch_cnt + 64'd1;
         if (resp_drop) drop_cnt  <= drop_cnt + 32'd1;
      end
   end

   assign perf_fetch_cnt = fetch_cnt;
   assign perf_drop_cnt  = drop_cnt;
`else
   assign perf_fetch_cnt = '0;
   assign perf_drop_cnt  = '0;
`endif

endmodule

// File: tb/tb_pipeline_if_stage5.sv
// Scoreboarded bench for pipeline_if_stage5: directed fetch, stall, redirect, wrap and reset scenarios.
module tb_pipeline_if_stage5;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        branch_taken_EXB;
   logic [63:0] branch_target_EXB;
   logic        imem_req;
   logic [63:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [63:0] pc_IF;
   logic [31:0] instr_IF;
   logic        valid_IF;
   logic [63:0] perf_fetch_cnt;
   logic [31:0] perf_drop_cnt;

   localparam logic [31:0] NOP = 32'h0000_0013;

   int n_checks = 0;
   int n_fail   = 0;

   logic [63:0] exp_addr_q[$];
   logic [63:0] exp_pc_q[$];

   // memory model state
   int          mem_lat = 0;
   bit          mem_pend = 0;
   int          mem_cnt = 0;
   logic [63:0] mem_paddr;
   bit          mem_g, mem_r;
   logic [63:0] mem_a;
   int          mem_l;

   pipeline_if_stage5 dut (
      .clk               (clk),
      .reset             (reset),
      .stall             (stall),
      .branch_taken_EXB  (branch_taken_EXB),
      .branch_target_EXB (branch_target_EXB),
      .imem_req          (imem_req),
      .imem_addr         (imem_addr),
      .imem_gnt          (imem_gnt),
      .imem_rvalid       (imem_rvalid),
      .imem_rdata        (imem_rdata),
      .pc_IF             (pc_IF),
      .instr_IF          (instr_IF),
      .valid_IF          (valid_IF),
      .perf_fetch_cnt    (perf_fetch_cnt),
      .perf_drop_cnt     (perf_drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [63:0] addr);
      return {16'hC0DE, addr[15:0]};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Memory: grant sampled at the edge, response driven 1+mem_lat cycles later.
   always @(posedge clk) begin
      mem_g = imem_req && imem_gnt && !reset;
      mem_a = imem_addr;
      mem_r = reset;
      mem_l = mem_lat;
      #1;
      imem_rvalid = 1'b0;
      if (mem_r) begin
         mem_pend = 0;
      end else begin
         if (mem_pend) begin
            if (mem_cnt == 0) begin
               imem_rvalid = 1'b1;
               imem_rdata  = mem_word(mem_paddr);
               mem_pend    = 0;
            end else begin
               mem_cnt--;
            end
         end
         if (mem_g) begin
            if (mem_l == 0) begin
               imem_rvalid = 1'b1;
               imem_rdata  = mem_word(mem_a);
            end else begin
               mem_pend  = 1;
               mem_paddr = mem_a;
               mem_cnt   = mem_l - 1;
            end
         end
      end
   end

   // Monitor: grants pop the address queue, instructions accepted by decode pop the pc queue.
   always @(negedge clk) begin
      if (!reset) begin
         if (imem_req && imem_gnt) begin
            if (exp_addr_q.size() == 0) check("unexpected_grant", imem_addr, 64'hDEAD);
            else check("imem_addr", imem_addr, exp_addr_q.pop_front());
         end
         if (valid_IF && !stall) begin
            if (exp_pc_q.size() == 0) begin
               check("unexpected_instr", pc_IF, 64'hDEAD);
            end else begin
               logic [63:0] epc;
               epc = exp_pc_q.pop_front();
               check("pc_IF", pc_IF, epc);
               check("instr_IF", {32'h0, instr_IF}, {32'h0, mem_word(epc)});
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_pc(input logic [63:0] pc);
      for (int i = 0; i < 60; i++) begin
         step();
         if (valid_IF && pc_IF == pc) return;
      end
      n_checks++;
      n_fail++;
      $display("FAIL wait_pc timeout: pc_IF %h never valid, required %h", pc_IF, pc);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      stall = 1'b0;
      branch_taken_EXB = 1'b0;
      branch_target_EXB = '0;
      imem_gnt = 1'b1;
      imem_rvalid = 1'b0;
      imem_rdata = '0;

      repeat (3) step();
      check("rst_valid", {63'h0, valid_IF}, 64'h0);
      check("rst_pc", pc_IF, 64'h0);
      check("rst_instr", {32'h0, instr_IF}, {32'h0, NOP});
      check("rst_req", {63'h0, imem_req}, 64'h0);
      check("rst_fetch_cnt", perf_fetch_cnt, 64'h0);
      check("rst_drop_cnt", {32'h0, perf_drop_cnt}, 64'h0);

      // zero-wait fetch: one instruction every 2 cycles
      exp_addr_q = '{64'h0, 64'h4, 64'h8, 64'hC, 64'h10};
      exp_pc_q   = '{64'h0, 64'h4, 64'h8, 64'hC};
      reset = 1'b0;
      wait_pc(64'h0);
      step();
      check("bubble_valid", {63'h0, valid_IF}, 64'h0);
      check("bubble_instr", {32'h0, instr_IF}, {32'h0, NOP});
      step();
      check("second_valid", {63'h0, valid_IF}, 64'h1);
      check("second_pc", pc_IF, 64'h4);

      // stall 5 cycles: output frozen, 0x8 parked in hold, no new request
      stall = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         check("stall_pc", pc_IF, 64'h4);
         check("stall_valid", {63'h0, valid_IF}, 64'h1);
         check("stall_req", {63'h0, imem_req}, 64'h0);
      end
      stall = 1'b0;
      wait_pc(64'hC);

      // redirect while 0x10 is outstanding
      mem_lat = 3;
      step();
      check("wait_req", {63'h0, imem_req}, 64'h0);
      exp_addr_q.push_back(64'h200);
      exp_pc_q.push_back(64'h200);
      branch_taken_EXB = 1'b1;
      branch_target_EXB = 64'h200;
      step();
      branch_taken_EXB = 1'b0;
      mem_lat = 0;
      check("redir_valid", {63'h0, valid_IF}, 64'h0);
      wait_pc(64'h200);
`ifdef PIPE_IF_PERF_EN
      check("drop_cnt", {32'h0, perf_drop_cnt}, 64'h1);
`else
      check("drop_cnt_off", {32'h0, perf_drop_cnt}, 64'h0);
`endif

      // redirect together with stall and a full hold buffer
      exp_addr_q.push_back(64'h204);
      exp_addr_q.push_back(64'h208);
      wait_pc(64'h204);
      stall = 1'b1;
      repeat (3) step();
      check("full_req", {63'h0, imem_req}, 64'h0);
      check("full_pc", pc_IF, 64'h204);
      exp_addr_q.push_back(64'h1000);
      exp_pc_q.push_back(64'h1000);
      branch_taken_EXB = 1'b1;
      branch_target_EXB = 64'h1000;
      step();
      branch_taken_EXB = 1'b0;
      stall = 1'b0;
      #1;
      check("flush_valid", {63'h0, valid_IF}, 64'h0);
      check("flush_instr", {32'h0, instr_IF}, {32'h0, NOP});
      check("flush_req", {63'h0, imem_req}, 64'h1);
      check("flush_addr", imem_addr, 64'h1000);

      // unaligned target, redirect from S_REQ suppresses the request
      wait_pc(64'h1000);
      branch_taken_EXB = 1'b1;
      branch_target_EXB = 64'h203;
      #1;
      check("redir_req_suppressed", {63'h0, imem_req}, 64'h0);
      exp_addr_q.push_back(64'h200);
      exp_pc_q.push_back(64'h200);
      step();
      branch_taken_EXB = 1'b0;
      #1;
      check("aligned_addr", imem_addr, 64'h200);
      wait_pc(64'h200);

      // address wrap at the top of the 64-bit space
      exp_addr_q.push_back(64'hFFFF_FFFF_FFFF_FFFC);
      exp_addr_q.push_back(64'h0);
      exp_pc_q.push_back(64'hFFFF_FFFF_FFFF_FFFC);
      exp_pc_q.push_back(64'h0);
      branch_taken_EXB = 1'b1;
      branch_target_EXB = 64'hFFFF_FFFF_FFFF_FFFC;
      step();
      branch_taken_EXB = 1'b0;
      wait_pc(64'hFFFF_FFFF_FFFF_FFFC);
      wait_pc(64'h0);

      // reset while a request is outstanding
      mem_lat = 3;
      exp_addr_q.push_back(64'h4);
      step();
      check("pre_rst_wait_req", {63'h0, imem_req}, 64'h0);
      reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         check("mid_rst_valid", {63'h0, valid_IF}, 64'h0);
         check("mid_rst_pc", pc_IF, 64'h0);
         check("mid_rst_instr", {32'h0, instr_IF}, {32'h0, NOP});
         check("mid_rst_req", {63'h0, imem_req}, 64'h0);
      end
      mem_lat = 0;
      exp_addr_q.push_back(64'h0);
      exp_addr_q.push_back(64'h4);
      exp_pc_q.push_back(64'h0);
      exp_pc_q.push_back(64'h4);
      reset = 1'b0;
      #1;
      check("post_rst_addr", imem_addr, 64'h0);
      wait_pc(64'h0);
      wait_pc(64'h4);
      imem_gnt = 1'b0;
`ifdef PIPE_IF_PERF_EN
      check("fetch_cnt", perf_fetch_cnt, 64'h2);
      check("drop_cnt_after_rst", {32'h0, perf_drop_cnt}, 64'h0);
`else
      check("fetch_cnt_off", perf_fetch_cnt, 64'h0);
      check("drop_cnt_off_end", {32'h0, perf_drop_cnt}, 64'h0);
`endif
      repeat (4) step();
      check("addr_q_drained", 64'(exp_addr_q.size()), 64'h0);
      check("pc_q_drained", 64'(exp_pc_q.size()), 64'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
